// File: rtl/culsans_pkg.sv
// Shared AXI channel types and constants for the culsans memory responder.
// CULSANS_MEM_RESP_EXCL_EN (used by the top) adds a single-entry exclusive monitor.
package culsans_pkg;

  localparam logic [63:0] DRAMBase        = 64'h8000_0000;
  localparam int unsigned MemRespMaxBurst = 256;
  localparam int unsigned IdWidth         = 4;
  localparam int unsigned UserWidth       = 1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [63:0]          addr_t;
  typedef logic [UserWidth-1:0] user_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    logic [5:0] atop;
    user_t      user;
  } aw_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    user_t       user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic       lock;
    logic [3:0] cache;
    logic [2:0] prot;
    logic [3:0] qos;
    logic [3:0] region;
    user_t      user;
  } ar_chan_t;

  typedef struct packed {
    id_t         id;
    logic [63:0] data;
    logic [3:0]  resp;
    logic        last;
    user_t       user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;

  typedef enum logic {R_IDLE, R_BURST} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  // Addresses below base wrap to a huge offset, so one compare covers both ends.
  function automatic logic beat_err(input addr_t addr, input addr_t base,
                                    input int unsigned words, input logic [2:0] size,
                                    input logic [1:0] burst);
    return ((addr - base) >= (64'(words) << 3)) || (size != 3'd3) || (burst == BURST_WRAP);
  endfunction

endpackage

// File: rtl/culsans_axi_beat_ctr.sv
// Per-burst beat counter: current/next beat address and last-beat flag.
module culsans_axi_beat_ctr
  import culsans_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  addr_t      addr_i,
  input  logic [7:0] len_i,
  input  logic [1:0] burst_i,
  input  logic       adv_i,
  output addr_t      addr_o,
  output addr_t      next_addr_o,
  output logic       last_o
);
  localparam int unsigned CntWidth = $clog2(MemRespMaxBurst);

  addr_t               addr_q, addr_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] len_q, len_d;
  logic                fixed_q, fixed_d;

  assign addr_o      = addr_q;
  assign next_addr_o = fixed_q ? addr_q : addr_q + 64'd8;
  assign last_o      = (cnt_q == len_q);

  always_comb begin
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    fixed_d = fixed_q;
    if (load_i) begin
      addr_d  = addr_i;
      cnt_d   = '0;
      len_d   = CntWidth'(len_i);
      fixed_d = (burst_i == BURST_FIXED);
    end else if (adv_i) begin
      addr_d = next_addr_o;
      cnt_d  = cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      fixed_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      fixed_q <= fixed_d;
    end
  end

endmodule

// File: rtl/culsans_axi_mem_responder.sv
// AXI slave backed by a 64-bit word array; independent single-outstanding read/write FSMs.
// Define CULSANS_MEM_RESP_EXCL_EN to add a single-entry exclusive-access monitor.
module culsans_axi_mem_responder
  import culsans_pkg::*;
#(
  parameter int unsigned NumWords = 1024,
  parameter logic [63:0] BaseAddr = DRAMBase
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  req_t  req_i,
  output resp_t resp_o
);
  localparam int unsigned IdxWidth = $clog2(NumWords);

  function automatic logic [IdxWidth-1:0] word_idx(input addr_t a);
    return IdxWidth'((a - BaseAddr) >> 3);
  endfunction

  logic [63:0] mem_q [NumWords];
  logic [63:0] r_rdata_q;

  r_state_e   r_state_q, r_state_d;
  w_state_e   w_state_q, w_state_d;
  logic       ar_ready, r_valid, aw_ready, w_ready, b_valid;
  logic       ar_hs, r_hs, aw_hs, w_hs, b_hs;
  addr_t      r_addr, r_next_addr, w_addr, w_next_addr, rd_addr;
  logic       r_last, w_last, rd_en, mem_we, w_beat_err;
  id_t        r_id_q, r_id_d, w_id_q, w_id_d;
  logic [2:0] r_size_q, r_size_d, w_size_q, w_size_d;
  logic [1:0] r_burst_q, r_burst_d, w_burst_q, w_burst_d;
  logic       r_lock_q, r_lock_d, r_err_q, r_err_d;
  logic       w_atop_q, w_atop_d, w_slverr_q, w_slverr_d;
  logic       w_excl_q, w_excl_d, w_excl_ok_q, w_excl_ok_d;
  logic       ar_lock_en, aw_lock_en, aw_excl_ok;
  logic       unused_bits;

  culsans_axi_beat_ctr i_r_ctr (
    .clk_i, .rst_i,
    .load_i(ar_hs), .addr_i(req_i.ar.addr), .len_i(req_i.ar.len), .burst_i(req_i.ar.burst),
    .adv_i(r_hs && !r_last), .addr_o(r_addr), .next_addr_o(r_next_addr), .last_o(r_last)
  );

  culsans_axi_beat_ctr i_w_ctr (
    .clk_i, .rst_i,
    .load_i(aw_hs), .addr_i(req_i.aw.addr), .len_i(req_i.aw.len), .burst_i(req_i.aw.burst),
    .adv_i(w_hs), .addr_o(w_addr), .next_addr_o(w_next_addr), .last_o(w_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_BURST;
      R_BURST: if (r_hs && r_last) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: if (aw_hs) w_state_d = W_DATA;
      W_DATA: if (w_hs && (req_i.w.last || w_last)) w_state_d = W_RESP;
      W_RESP: if (b_hs) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Handshake outputs are masked by rst_i so they read 0 for the whole reset window.
  always_comb begin
    ar_ready = (r_state_q == R_IDLE) && !rst_i;
    r_valid  = (r_state_q == R_BURST) && !rst_i;
    aw_ready = (w_state_q == W_IDLE) && !rst_i;
    w_ready  = (w_state_q == W_DATA) && !rst_i;
    b_valid  = (w_state_q == W_RESP) && !rst_i;
  end

  assign ar_hs = ar_ready && req_i.ar_valid;
  assign r_hs  = r_valid && req_i.r_ready;
  assign aw_hs = aw_ready && req_i.aw_valid;
  assign w_hs  = w_ready && req_i.w_valid;
  assign b_hs  = b_valid && req_i.b_ready;

  // The next beat is fetched on AR accept and on each non-last R handshake.
  always_comb begin
    r_id_d    = r_id_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_lock_d  = r_lock_q;
    rd_addr   = r_next_addr;
    rd_en     = 1'b0;
    if (ar_hs) begin
      r_id_d    = req_i.ar.id;
      r_size_d  = req_i.ar.size;
      r_burst_d = req_i.ar.burst;
      r_lock_d  = ar_lock_en;
      rd_addr   = req_i.ar.addr;
      rd_en     = 1'b1;
    end else if (r_hs && !r_last) begin
      rd_en = 1'b1;
    end
    r_err_d = rd_en ? beat_err(rd_addr, BaseAddr, NumWords, r_size_d, r_burst_d) : r_err_q;
  end

  assign w_beat_err = beat_err(w_addr, BaseAddr, NumWords, w_size_q, w_burst_q);
  assign mem_we     = w_hs && !w_beat_err && !w_atop_q && (!w_excl_q || w_excl_ok_q);

  always_comb begin
    w_id_d      = w_id_q;
    w_size_d    = w_size_q;
    w_burst_d   = w_burst_q;
    w_atop_d    = w_atop_q;
    w_slverr_d  = w_slverr_q;
    w_excl_d    = w_excl_q;
    w_excl_ok_d = w_excl_ok_q;
    if (aw_hs) begin
      w_id_d      = req_i.aw.id;
      w_size_d    = req_i.aw.size;
      w_burst_d   = req_i.aw.burst;
      w_atop_d    = |req_i.aw.atop;
      w_slverr_d  = |req_i.aw.atop;
      w_excl_d    = aw_lock_en;
      w_excl_ok_d = aw_excl_ok;
    end else if (w_hs) begin
      w_slverr_d = w_slverr_q | w_beat_err | (req_i.w.last != w_last);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_id_q      <= '0;
      r_size_q    <= '0;
      r_burst_q   <= '0;
      r_lock_q    <= 1'b0;
      r_err_q     <= 1'b0;
      w_id_q      <= '0;
      w_size_q    <= '0;
      w_burst_q   <= '0;
      w_atop_q    <= 1'b0;
      w_slverr_q  <= 1'b0;
      w_excl_q    <= 1'b0;
      w_excl_ok_q <= 1'b0;
    end else begin
      r_id_q      <= r_id_d;
      r_size_q    <= r_size_d;
      r_burst_q   <= r_burst_d;
      r_lock_q    <= r_lock_d;
      r_err_q     <= r_err_d;
      w_id_q      <= w_id_d;
      w_size_q    <= w_size_d;
      w_burst_q   <= w_burst_d;
      w_atop_q    <= w_atop_d;
      w_slverr_q  <= w_slverr_d;
      w_excl_q    <= w_excl_d;
      w_excl_ok_q <= w_excl_ok_d;
    end
  end

  // Storage is never reset; the registered read returns pre-write data on a same-cycle collision.
  always_ff @(posedge clk_i) begin
    if (rd_en) r_rdata_q <= mem_q[word_idx(rd_addr)];
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (req_i.w.strb[b]) mem_q[word_idx(w_addr)][8*b +: 8] <= req_i.w.data[8*b +: 8];
      end
    end
  end

`ifdef CULSANS_MEM_RESP_EXCL_EN
  logic        resv_valid_q, resv_valid_d;
  id_t         resv_id_q, resv_id_d;
  logic [60:0] resv_word_q, resv_word_d;

  assign ar_lock_en = req_i.ar.lock;
  assign aw_lock_en = req_i.aw.lock;
  assign aw_excl_ok = resv_valid_q && (resv_id_q == req_i.aw.id) &&
                      (resv_word_q == req_i.aw.addr[63:3]);

  always_comb begin
    resv_valid_d = resv_valid_q;
    resv_id_d    = resv_id_q;
    resv_word_d  = resv_word_q;
    if (mem_we && (w_addr[63:3] == resv_word_q)) resv_valid_d = 1'b0;
    if (ar_hs && req_i.ar.lock) begin
      resv_valid_d = 1'b1;
      resv_id_d    = req_i.ar.id;
      resv_word_d  = req_i.ar.addr[63:3];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resv_valid_q <= 1'b0;
      resv_id_q    <= '0;
      resv_word_q  <= '0;
    end else begin
      resv_valid_q <= resv_valid_d;
      resv_id_q    <= resv_id_d;
      resv_word_q  <= resv_word_d;
    end
  end
`else
  assign ar_lock_en = 1'b0;
  assign aw_lock_en = 1'b0;
  assign aw_excl_ok = 1'b0;
`endif

  always_comb begin
    resp_o          = '0;
    resp_o.ar_ready = ar_ready;
    resp_o.aw_ready = aw_ready;
    resp_o.w_ready  = w_ready;
    resp_o.b_valid  = b_valid;
    resp_o.r_valid  = r_valid;
    if (b_valid) begin
      resp_o.b.id   = w_id_q;
      resp_o.b.resp = w_slverr_q ? RESP_SLVERR :
                      (w_excl_q && w_excl_ok_q) ? RESP_EXOKAY : RESP_OKAY;
    end
    if (r_valid) begin
      resp_o.r.id   = r_id_q;
      resp_o.r.data = r_err_q ? 64'd0 : r_rdata_q;
      resp_o.r.resp = {2'b00, r_err_q ? RESP_SLVERR : (r_lock_q ? RESP_EXOKAY : RESP_OKAY)};
      resp_o.r.last = r_last;
    end
  end

  assign unused_bits = ^{req_i.aw.cache, req_i.aw.prot, req_i.aw.qos, req_i.aw.region,
                         req_i.aw.user, req_i.aw.lock, req_i.w.user, req_i.ar.cache,
                         req_i.ar.prot, req_i.ar.qos, req_i.ar.region, req_i.ar.user,
                         req_i.ar.lock, r_addr, w_next_addr};

endmodule

// File: tb/tb_culsans_axi_mem_responder.sv
// Scoreboard bench for culsans_axi_mem_responder; honours CULSANS_MEM_RESP_EXCL_EN.
module tb_culsans_axi_mem_responder;
  import culsans_pkg::*;

  typedef struct {
    logic [3:0]  id;
    logic [63:0] data;
    logic [3:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  logic   clk = 1'b0;
  logic   rst_i;
  req_t   req;
  resp_t  resp;
  int     checks = 0;
  int     errors = 0;
  r_exp_t rq[$];
  b_exp_t bq[$];
  logic   stall_prev = 1'b0;
  r_chan_t stall_snap;

  always #5 clk = ~clk;

  culsans_axi_mem_responder #(.NumWords(1024), .BaseAddr(64'h8000_0000)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req), .resp_o(resp)
  );

  // Monitor: pops expectations on every R/B handshake, and checks R stability during stalls.
  always @(negedge clk) begin
    if (rst_i) begin
      stall_prev = 1'b0;
    end else begin
      if (resp.r_valid && req.r_ready) begin
        stall_prev = 1'b0;
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL r_unexpected: got beat data=%h id=%0d, required no beat", resp.r.data, resp.r.id);
        end else begin
          r_exp_t e;
          e = rq.pop_front();
          if ({resp.r.id, resp.r.data, resp.r.resp, resp.r.last} !== {e.id, e.data, e.resp, e.last}) begin
            errors++;
            $display("FAIL r_beat: got id=%0d data=%h resp=%h last=%b, required id=%0d data=%h resp=%h last=%b",
                     resp.r.id, resp.r.data, resp.r.resp, resp.r.last, e.id, e.data, e.resp, e.last);
          end else begin
            $display("R  id=%0d data=%h resp=%h last=%b", resp.r.id, resp.r.data, resp.r.resp, resp.r.last);
          end
        end
      end else if (resp.r_valid && !req.r_ready) begin
        if (stall_prev) begin
          checks++;
          if ({resp.r.id, resp.r.data, resp.r.last} !== {stall_snap.id, stall_snap.data, stall_snap.last}) begin
            errors++;
            $display("FAIL r_stall_stable: got id=%0d data=%h last=%b, required id=%0d data=%h last=%b",
                     resp.r.id, resp.r.data, resp.r.last, stall_snap.id, stall_snap.data, stall_snap.last);
          end
        end
        stall_snap = resp.r;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end

      if (resp.b_valid && req.b_ready) begin
        checks++;
        if (bq.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected: got id=%0d resp=%0d, required no response", resp.b.id, resp.b.resp);
        end else begin
          b_exp_t e;
          e = bq.pop_front();
          if ({resp.b.id, resp.b.resp} !== {e.id, e.resp}) begin
            errors++;
            $display("FAIL b_resp: got id=%0d resp=%0d, required id=%0d resp=%0d",
                     resp.b.id, resp.b.resp, e.id, e.resp);
          end else begin
            $display("B  id=%0d resp=%0d", resp.b.id, resp.b.resp);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_r(input logic [3:0] id, input logic [63:0] data0, input int len,
                        input logic [1:0] rsp, input logic fixed);
    for (int i = 0; i <= len; i++) begin
      r_exp_t e;
      e.id   = id;
      e.data = fixed ? data0 : data0 + 64'(i);
      e.resp = {2'b00, rsp};
      e.last = (i == len);
      rq.push_back(e);
    end
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                       input logic [1:0] burst, input logic lock);
    int n = 0;
    req.ar       = '0;
    req.ar.id    = id;
    req.ar.addr  = addr;
    req.ar.len   = len;
    req.ar.size  = 3'd3;
    req.ar.burst = burst;
    req.ar.lock  = lock;
    req.ar_valid = 1'b1;
    while (!resp.ar_ready && n < 100) begin tick(); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL ar_timeout: got ar_ready=0, required 1");
    end
    tick();
    req.ar_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                             input logic [63:0] data0, input logic [7:0] strb, input logic lock,
                             input logic [1:0] exp_resp);
    b_exp_t e;
    int n = 0;
    e.id = id;
    e.resp = exp_resp;
    bq.push_back(e);
    req.aw       = '0;
    req.aw.id    = id;
    req.aw.addr  = addr;
    req.aw.len   = len;
    req.aw.size  = 3'd3;
    req.aw.burst = BURST_INCR;
    req.aw.lock  = lock;
    req.aw_valid = 1'b1;
    while (!resp.aw_ready && n < 100) begin tick(); n++; end
    tick();
    req.aw_valid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      req.w.data  = data0 + 64'(i);
      req.w.strb  = strb;
      req.w.last  = (i == int'(len));
      req.w_valid = 1'b1;
      while (!resp.w_ready && n < 100) begin tick(); n++; end
      tick();
      req.w_valid = 1'b0;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL w_timeout: got ready=0, required 1");
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin tick(); n++; end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_done: got pending r=%0d b=%0d, required 0", rq.size(), bq.size());
      rq.delete();
      bq.delete();
    end
  endtask

  initial begin
    req         = '0;
    req.b_ready = 1'b1;
    req.r_ready = 1'b1;
    rst_i       = 1'b1;
    repeat (3) tick();
    check("rst_ar_ready", 64'(resp.ar_ready), 64'd0);
    check("rst_aw_ready", 64'(resp.aw_ready), 64'd0);
    check("rst_w_ready",  64'(resp.w_ready),  64'd0);
    check("rst_b_valid",  64'(resp.b_valid),  64'd0);
    check("rst_r_valid",  64'(resp.r_valid),  64'd0);
    check("rst_r_data",   resp.r.data,        64'd0);
    rst_i = 1'b0;
    #1;
    check("post_rst_ar_ready", 64'(resp.ar_ready), 64'd1);
    check("post_rst_aw_ready", 64'(resp.aw_ready), 64'd1);

    // Four-beat INCR write, then read back in order.
    write_burst(4'd1, 64'h8000_0010, 8'd3, 64'hA0, 8'hFF, 1'b0, RESP_OKAY);
    wait_done();
    push_r(4'd3, 64'hA0, 3, RESP_OKAY, 1'b0);
    do_ar(4'd3, 64'h8000_0010, 8'd3, BURST_INCR, 1'b0);
    wait_done();

    // FIXED burst repeats word 3.
    push_r(4'd4, 64'hA1, 1, RESP_OKAY, 1'b1);
    do_ar(4'd4, 64'h8000_0018, 8'd1, BURST_FIXED, 1'b0);
    wait_done();

    // Five-cycle r_ready stall after the first beat.
    push_r(4'd5, 64'hA0, 3, RESP_OKAY, 1'b0);
    do_ar(4'd5, 64'h8000_0010, 8'd3, BURST_INCR, 1'b0);
    tick();
    req.r_ready = 1'b0;
    repeat (5) tick();
    req.r_ready = 1'b1;
    wait_done();

    // Out-of-range accesses; 0x8000_2000 would alias word 0 if not suppressed.
    write_burst(4'd1, 64'h8000_0000, 8'd0, 64'hDEAD_BEEF_0000_0001, 8'hFF, 1'b0, RESP_OKAY);
    wait_done();
    push_r(4'd6, 64'd0, 0, RESP_SLVERR, 1'b0);
    do_ar(4'd6, 64'h8000_2000, 8'd0, BURST_INCR, 1'b0);
    wait_done();
    write_burst(4'd7, 64'h8000_2000, 8'd0, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0, RESP_SLVERR);
    wait_done();
    push_r(4'd6, 64'hDEAD_BEEF_0000_0001, 0, RESP_OKAY, 1'b0);
    do_ar(4'd6, 64'h8000_0000, 8'd0, BURST_INCR, 1'b0);
    wait_done();

    // Byte-strobe merge.
    write_burst(4'd2, 64'h8000_0100, 8'd0, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, RESP_OKAY);
    write_burst(4'd2, 64'h8000_0100, 8'd0, 64'hFFFF, 8'h03, 1'b0, RESP_OKAY);
    wait_done();
    push_r(4'd2, 64'h1122_3344_5566_FFFF, 0, RESP_OKAY, 1'b0);
    do_ar(4'd2, 64'h8000_0100, 8'd0, BURST_INCR, 1'b0);
    wait_done();

`ifdef CULSANS_MEM_RESP_EXCL_EN
    push_r(4'd2, 64'h1122_3344_5566_FFFF, 0, RESP_EXOKAY, 1'b0);
    do_ar(4'd2, 64'h8000_0100, 8'd0, BURST_INCR, 1'b1);
    wait_done();
    write_burst(4'd1, 64'h8000_0100, 8'd0, 64'h55, 8'hFF, 1'b0, RESP_OKAY);
    write_burst(4'd2, 64'h8000_0100, 8'd0, 64'h99, 8'hFF, 1'b1, RESP_OKAY);
    wait_done();
    push_r(4'd2, 64'h55, 0, RESP_OKAY, 1'b0);
    do_ar(4'd2, 64'h8000_0100, 8'd0, BURST_INCR, 1'b0);
    wait_done();
    push_r(4'd2, 64'h55, 0, RESP_EXOKAY, 1'b0);
    do_ar(4'd2, 64'h8000_0100, 8'd0, BURST_INCR, 1'b1);
    wait_done();
    write_burst(4'd2, 64'h8000_0100, 8'd0, 64'h77, 8'hFF, 1'b1, RESP_EXOKAY);
    wait_done();
`else
    push_r(4'd2, 64'h1122_3344_5566_FFFF, 0, RESP_OKAY, 1'b0);
    do_ar(4'd2, 64'h8000_0100, 8'd0, BURST_INCR, 1'b1);
    wait_done();
    write_burst(4'd2, 64'h8000_0100, 8'd0, 64'h77, 8'hFF, 1'b1, RESP_OKAY);
    wait_done();
`endif
    push_r(4'd2, 64'h77, 0, RESP_OKAY, 1'b0);
    do_ar(4'd2, 64'h8000_0100, 8'd0, BURST_INCR, 1'b0);
    wait_done();

    // Reset while beat 2 of a len-7 read is presented.
    push_r(4'd4, 64'hA0, 1, RESP_OKAY, 1'b0);
    rq[1].last = 1'b0;
    do_ar(4'd4, 64'h8000_0010, 8'd7, BURST_INCR, 1'b0);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    check("midrst_r_valid", 64'(resp.r_valid), 64'd0);
    check("midrst_beats_consumed", 64'(rq.size()), 64'd0);
    rq.delete();
    rst_i = 1'b0;
    #1;
    check("midrst_ar_ready", 64'(resp.ar_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("midrst_no_more_beats", 64'(resp.r_valid), 64'd0);
    end
    check("midrst_no_b", 64'(resp.b_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/culsans_axi_mem_responder.md
CULSANS_AXI_MEM_RESPONDER -- requirements
Module: culsans_axi_mem_responder

Interface
REQ-001 SHALL have parameter NumWords, default 1024, giving the number of 64-bit words in backing storage.
REQ-002 SHALL have parameter BaseAddr, default 64'h8000_0000 (DRAMBase), giving the byte address of word 0.
REQ-003 SHALL have port clk_i  input  1  as the sole clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_i  input  1  as the reset; it is synchronous and active-high.
REQ-005 SHALL have port req_i  input  culsans_pkg::req_t  carrying the AW/W/B-ready/AR/R-ready request from the initiator.
REQ-006 SHALL have port resp_o  output  culsans_pkg::resp_t  carrying ready signals and the B/R responses to the initiator.

Function
REQ-007 SHALL run read and write paths as independent FSMs, each with at most one outstanding transaction.
REQ-008 Read FSM SHALL have states R_IDLE and R_BURST; ar_ready=1 only in R_IDLE; an AR handshake latches id, addr, len, size and burst, and moves the FSM to R_BURST.
REQ-009 In R_BURST, r_valid SHALL be 1; beat n SHALL carry mem[(addr_n-BaseAddr)>>3], r.id = latched id, and r.last=1 only on beat len; the first beat appears the cycle after the AR handshake.
REQ-010 R channel contents SHALL be held stable while r_valid=1 and r_ready=0; on the handshake of the last beat the FSM SHALL return to R_IDLE, with ar_ready=1 in the following cycle.
REQ-011 Beat address SHALL advance by 8 for INCR bursts, stay constant for FIXED, and wrap modulo 2^64 with no special handling.
REQ-012 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP; aw_ready=1 only in W_IDLE; w_ready=1 only in W_DATA; b_valid=1 only in W_RESP, held until b_ready.
REQ-013 Each W beat SHALL update only the bytes enabled by w.strb at the current beat address; the FSM SHALL move to W_RESP on the beat with w.last=1.
REQ-014 B SHALL report SLVERR if w.last is asserted on a beat other than beat len; w.last missing on beat len SHALL be treated as last, with SLVERR, and the FSM SHALL move to W_RESP.
REQ-015 Any beat with an address outside [BaseAddr, BaseAddr+8*NumWords), size!=3 or burst=WRAP SHALL be errored: read data 0, write suppressed, and the transaction response SLVERR.
REQ-016 AW with atop!=0 SHALL perform no writes and return SLVERR on B; AW with atop[5]=1 is outside scope and produces no R response.
REQ-017 r.resp[3:2] (PassDirty, IsShared) and every user field SHALL be 0; the response otherwise SHALL be OKAY.
REQ-018 A same-cycle write and read beat to the same word SHALL return the pre-write data; the write SHALL be visible from the next cycle.

Reset
REQ-019 While rst_i=1, both FSMs SHALL be in their idle states; all ready and valid outputs SHALL be 0; resp_o data, id and resp fields SHALL be 0; the exclusive reservation SHALL be invalid.
REQ-020 Reset asserted mid-burst SHALL abandon the burst without further beats or B response; memory contents SHALL NOT be reset.
REQ-021 ar_ready and aw_ready SHALL rise in the first cycle after rst_i deasserts.

Configuration
REQ-022 Macro CULSANS_MEM_RESP_EXCL_EN defined SHALL enable a single-entry exclusive monitor.
REQ-023 With CULSANS_MEM_RESP_EXCL_EN: an AR with lock=1 SHALL record {id, word address} and return EXOKAY on every beat.
REQ-024 With CULSANS_MEM_RESP_EXCL_EN: an AW with lock=1 whose id and address match the reservation SHALL write and return EXOKAY, then clear the reservation; a non-matching exclusive AW SHALL return OKAY and not write.
REQ-025 With CULSANS_MEM_RESP_EXCL_EN: any completed non-exclusive write to the reserved word SHALL clear the reservation.
REQ-026 Without CULSANS_MEM_RESP_EXCL_EN: lock SHALL be ignored, no monitor logic SHALL exist, and EXOKAY SHALL never be returned.

Structure
REQ-027 SHALL use req_t, resp_t and the DRAMBase constant from culsans_pkg; FSM state enums and a MemRespMaxBurst constant (256) SHALL be added to culsans_pkg.
REQ-028 SHALL contain one sub-module, culsans_axi_beat_ctr (beat counter, next-address and last-beat logic), instantiated once for the read path and once for the write path.

Verification
REQ-029 The bench SHALL cover: AW addr 0x8000_0010, len 3, INCR, data 0xA0..0xA3, strb 0xFF -> B OKAY; then AR with the same parameters -> 4 beats 0xA0..0xA3 in order, last only on the 4th beat.
REQ-030 The bench SHALL cover: r_ready held low for 5 cycles mid-burst -> r.data, r.id and r.last stable throughout; no beat lost or duplicated.
REQ-031 The bench SHALL cover: AR addr 0x8000_2000 with NumWords=1024 -> a single beat, data 0, resp SLVERR; AW at the same address with strb 0x0F -> B SLVERR and memory unchanged.
REQ-032 The bench SHALL cover: write word 0x1122334455667788, then strb 0x03 with data 0xFFFF -> readback 0x112233445566FFFF.
REQ-033 The bench SHALL cover: rst_i pulsed on beat 2 of a len-7 read -> no further r_valid; ar_ready=1 one cycle after release.
REQ-034 With CULSANS_MEM_RESP_EXCL_EN, the bench SHALL cover: exclusive read by id 2, then a normal write by id 1 to the same word, then an exclusive write by id 2 -> OKAY with no write.
